// File: rtl/demux_mux_pkg.sv
// demux_mux_pkg: shared channel count, select width and default data width for the 1:4 demux / 4:1 mux pair
package demux_mux_pkg;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  localparam int DEF_WIDTH = 3;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin arbiter, priority starts at ptr and wraps
module rr_arbiter_4
  import demux_mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W-1:0]  off;
  // rotate requests so ptr sits at bit 0, pick the first set bit, rotate the index back
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_CH-1:0];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    any = |req;
    grant_idx = ptr + off;
    grant = any ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end
endmodule

// File: rtl/four_one_rr_mux.sv
// four_one_rr_mux: merges four valid/ready channels into one tagged, registered stream by round robin
module four_one_rr_mux
  import demux_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any;
  logic             can_load;
  rr_arbiter_4 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );
  // ready goes only to the granted channel, and only when the output slot is free and out of reset
  always_comb begin
    can_load = !out_valid || out_ready;
    in_ready = (can_load && any && rst_n) ? grant : '0;
  end
  // output register and pointer: load the granted word, drain to empty when idle, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (can_load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[grant_idx*WIDTH +: WIDTH];
        out_sel  <= grant_idx;
        ptr      <= grant_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_four_one_rr_mux.sv
// tb_four_one_rr_mux: directed self-checking bench for the round-robin 4:1 mux
module tb_four_one_rr_mux;
  localparam int W = 3;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]     in_valid = '0;
  logic [3:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  four_one_rr_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 4'hF;
    #2;
    n_cmp++;
    if ({out_valid, out_data, out_sel, in_ready} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_initial: got v=%b d=%0d s=%0d rdy=%b want all 0", out_valid, out_data, out_sel, in_ready);
    end
    rst_n = 1'b1;
    in_valid = 4'b0001;
    set_ch(0, 3'd6);
    out_ready = 1'b0;
    step();
    n_cmp++;
    if (!(out_valid === 1'b1 && out_data === 3'd6)) begin
      n_err++;
      $display("FAIL reset_preload: got v=%b d=%0d want v=1 d=6", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_sel, in_ready} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_midstream: got v=%b d=%0d s=%0d rdy=%b want all 0", out_valid, out_data, out_sel, in_ready);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 4'b0100;
    set_ch(2, 3'd5);
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_after_ready: got %b want 0100", in_ready);
    end
    step();
    n_cmp++;
    if (!(out_valid === 1'b1 && out_data === 3'd5 && out_sel === 2'd2)) begin
      n_err++;
      $display("FAIL reset_after_out: got v=%b d=%0d s=%0d want v=1 d=5 s=2", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 4'b0010;
      set_ch(1, W'(k));
      step();
      n_cmp++;
      if (!(out_valid === 1'b1 && out_data === W'(k) && out_sel === 2'd1)) begin
        n_err++;
        $display("FAIL stream_%0d: got v=%b d=%0d s=%0d want v=1 d=%0d s=1", k, out_valid, out_data, out_sel, k);
      end
    end
    in_valid = '0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, W'(4 + i));
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (!(out_valid === 1'b1 && out_sel === 2'(k % 4) && out_data === W'(4 + k % 4))) begin
        n_err++;
        $display("FAIL fair_%0d: got v=%b s=%0d d=%0d want v=1 s=%0d d=%0d", k, out_valid, out_sel, out_data, k % 4, 4 + k % 4);
      end
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    set_ch(0, 3'd1);
    set_ch(3, 3'd6);
    in_valid = 4'b1001;
    step();
    n_cmp++;
    if (!(out_valid === 1'b1 && out_sel === 2'd3 && out_data === 3'd6)) begin
      n_err++;
      $display("FAIL bp_first: got v=%b s=%0d d=%0d want v=1 s=3 d=6", out_valid, out_sel, out_data);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready_%0d: got %b want 0000", k, in_ready);
      end
      step();
      n_cmp++;
      if (!(out_valid === 1'b1 && out_sel === 2'd3 && out_data === 3'd6)) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b s=%0d d=%0d want v=1 s=3 d=6", k, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 0001", in_ready);
    end
    step();
    n_cmp++;
    if (!(out_valid === 1'b1 && out_sel === 2'd0 && out_data === 3'd1)) begin
      n_err++;
      $display("FAIL bp_release_out: got v=%b s=%0d d=%0d want v=1 s=0 d=1", out_valid, out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_ptr_skip();
    set_ch(0, 3'd2);
    set_ch(2, 3'd7);
    in_valid = 4'b0001;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL skip_ready: got %b want 0001", in_ready);
    end
    step();
    n_cmp++;
    if (!(out_sel === 2'd0 && out_data === 3'd2)) begin
      n_err++;
      $display("FAIL skip_ch0: got s=%0d d=%0d want s=0 d=2", out_sel, out_data);
    end
    in_valid = 4'b0101;
    step();
    n_cmp++;
    if (!(out_sel === 2'd2 && out_data === 3'd7)) begin
      n_err++;
      $display("FAIL skip_ch2: got s=%0d d=%0d want s=2 d=7", out_sel, out_data);
    end
    step();
    n_cmp++;
    if (!(out_sel === 2'd0 && out_data === 3'd2)) begin
      n_err++;
      $display("FAIL skip_wrap: got s=%0d d=%0d want s=0 d=2", out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_idle_drain();
    set_ch(3, 3'd3);
    in_valid = 4'b1000;
    out_ready = 1'b0;
    step();
    in_valid = '0;
    step();
    n_cmp++;
    if (!(out_valid === 1'b1 && out_sel === 2'd3 && out_data === 3'd3)) begin
      n_err++;
      $display("FAIL drain_held: got v=%b s=%0d d=%0d want v=1 s=3 d=3", out_valid, out_sel, out_data);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_valid: got %b want 0", out_valid);
    end
    in_valid = 4'b0011;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL drain_ptr: got %b want 0001", in_ready);
    end
    in_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fairness();
    test_backpressure();
    test_ptr_skip();
    test_idle_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
